// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, 4-state fetch FSM (2-cycle memory), IR with decoded fields.
// Optional FETCH_MISALIGN_EN: misaligned fetches trap into a sticky FAULT state instead of being word-aligned.
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_load,
  input  logic        ins_load,
  input  logic [1:0]  mux_pcin,
  input  logic [31:0] alu_result,
  input  logic [31:0] aluout,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic        fetch_done,
  output logic        busy,
  output logic        misalign
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WAIT  = 3'd2,
    S_LATCH = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_fetch;
  logic [31:0] pc_nxt;
  logic        fault_entry;

  always_comb begin
    fault_entry = 1'b0;
`ifdef FETCH_MISALIGN_EN
    fault_entry = (state == S_IDLE) && ins_load && (pc[1:0] != 2'b00);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ins_load) state_nxt = fault_entry ? S_FAULT : S_ADDR;
      S_ADDR:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_IDLE;
`ifdef FETCH_MISALIGN_EN
      S_FAULT: state_nxt = S_FAULT;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_rd     = 1'b0;
    fetch_done = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE:  busy       = 1'b0;
      S_ADDR:  mem_rd     = 1'b1;
      S_WAIT:  mem_rd     = 1'b1;
      S_LATCH: fetch_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (mux_pcin)
      2'd0:    pc_nxt = alu_result;
      2'd1:    pc_nxt = aluout;
      2'd2:    pc_nxt = {pc_fetch[31:28], ir[25:0], 2'b00};
      default: pc_nxt = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'h0;
    else if (pc_load) pc <= pc_nxt;
  end

  // pc_fetch samples the pre-load pc, so a same-cycle pc_load never redirects the fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_fetch <= 32'h0;
    end else if ((state == S_IDLE) && ins_load) begin
`ifdef FETCH_MISALIGN_EN
      pc_fetch <= pc;
`else
      pc_fetch <= {pc[31:2], 2'b00};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ir <= 32'h0;
    else if (state == S_LATCH) ir <= mem_rdata;
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else if (fault_entry) misalign <= 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

  assign mem_addr = pc_fetch;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm16  = ir[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic against a transaction-level model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_load, ins_load;
  logic [1:0]  mux_pcin;
  logic [31:0] alu_result, aluout, mem_rdata;
  logic [31:0] mem_addr, pc, ir;
  logic        mem_rd, fetch_done, busy, misalign;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  instr_fetch dut (
    .clk(clk), .rst(rst), .pc_load(pc_load), .ins_load(ins_load), .mux_pcin(mux_pcin),
    .alu_result(alu_result), .aluout(aluout), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .pc(pc), .ir(ir),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
    .fetch_done(fetch_done), .busy(busy), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int rd_cnt, done_cnt;

  // Model: phase counts cycles since the fetch was accepted (0 = idle, 4 = faulted).
  int          ph;
  logic [31:0] m_pc, m_pf, m_ir;
  logic        m_mis;
  logic        fixed_valid;
  logic [31:0] fixed_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] exp_addr();
`ifdef FETCH_MISALIGN_EN
    return m_pf;
`else
    return {m_pf[31:2], 2'b00};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    ph = 0; m_pc = 0; m_pf = 0; m_ir = 0; m_mis = 0;
  endtask

  task automatic model_update();
    logic [31:0] old_pc;
    if (rst) begin
      model_reset();
      return;
    end
    old_pc = m_pc;
    if (pc_load) begin
      if (mux_pcin == 2'd0)      m_pc = alu_result;
      else if (mux_pcin == 2'd1) m_pc = aluout;
      else if (mux_pcin == 2'd2) m_pc = (m_pf & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
      else                       m_pc = 0;
    end
    if (ph == 0) begin
      if (ins_load) begin
        m_pf = old_pc;
        ph = 1;
`ifdef FETCH_MISALIGN_EN
        if (old_pc % 4 != 0) begin ph = 4; m_mis = 1; end
`endif
      end
    end else if (ph == 1 || ph == 2) begin
      ph = ph + 1;
    end else if (ph == 3) begin
      m_ir = mem_rdata;
      ph = 0;
    end
  endtask

  task automatic check_all();
    chk("busy",       {31'b0, busy},       {31'b0, ph != 0});
    chk("mem_rd",     {31'b0, mem_rd},     {31'b0, ph == 1 || ph == 2});
    chk("fetch_done", {31'b0, fetch_done}, {31'b0, ph == 3});
    chk("misalign",   {31'b0, misalign},   {31'b0, m_mis});
    chk("mem_addr",   mem_addr, exp_addr());
    chk("pc",         pc, m_pc);
    chk("ir",         ir, m_ir);
    chk("opcode",     {26'b0, opcode}, m_ir >> 26);
    chk("rs",         {27'b0, rs},     (m_ir >> 21) % 32);
    chk("rt",         {27'b0, rt},     (m_ir >> 16) % 32);
    chk("rd",         {27'b0, rd},     (m_ir >> 11) % 32);
    chk("shamt",      {27'b0, shamt},  (m_ir >> 6) % 32);
    chk("funct",      {26'b0, funct},  m_ir % 64);
    chk("imm16",      {16'b0, imm16},  m_ir % 65536);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    if (mem_rd === 1'b1) rd_cnt++;
    if (fetch_done === 1'b1) done_cnt++;
    @(posedge clk);
    model_update();
    #1;
    if (ph == 3) mem_rdata = fixed_valid ? fixed_data : mem_word(exp_addr());
    else         mem_rdata = $urandom;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic fetch_pulse();
    ins_load = 1'b1;
    cycle();
    ins_load = 1'b0;
  endtask

  task automatic load_pc(input logic [1:0] sel, input logic [31:0] v);
    pc_load = 1'b1; mux_pcin = sel; alu_result = v;
    cycle();
    pc_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1 model_reset();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_load = 0; ins_load = 0; mux_pcin = 0;
    alu_result = 0; aluout = 0; mem_rdata = 0; fixed_valid = 0; fixed_data = 0;
    rd_cnt = 0; done_cnt = 0;
    model_reset();
    #2 check_all();
    @(posedge clk); #1 rst = 1'b0;

    // First fetch after reset: fixed instruction word at address 0
    fixed_valid = 1; fixed_data = 32'h2008_0005;
    rd_cnt = 0; done_cnt = 0;
    fetch_pulse();
    run(4);
    fixed_valid = 0;
    chk("r27_rd_cycles", rd_cnt, 2);
    chk("r27_done_pulses", done_cnt, 1);
    chk("r27_opcode", {26'b0, opcode}, 32'h08);
    chk("r27_rt", {27'b0, rt}, 8);
    chk("r27_imm16", {16'b0, imm16}, 32'h5);

    // Simultaneous ins_load and pc_load: fetch uses the old pc
    load_pc(2'd0, 32'h4);
    ins_load = 1; pc_load = 1; mux_pcin = 0; alu_result = 32'h8;
    cycle();
    ins_load = 0; pc_load = 0;
    chk("r28_mem_addr", mem_addr, 32'h4);
    chk("r28_pc", pc, 32'h8);
    run(4);

    // Jump target from pc_fetch[31:28] and ir
    load_pc(2'd0, 32'h4000_0000);
    fixed_valid = 1; fixed_data = 32'h0800_0010;
    fetch_pulse();
    run(4);
    fixed_valid = 0;
    load_pc(2'd2, 32'h0);
    chk("r29_pc_jump", pc, 32'h4000_0040);

    // Wrap to zero and ins_load ignored while busy
    load_pc(2'd0, 32'hFFFF_FFFC);
    chk("r30_pc_top", pc, 32'hFFFF_FFFC);
    load_pc(2'd0, 32'h0);
    chk("r30_pc_wrap", pc, 32'h0);
    load_pc(2'd3, 32'h1234_5678);
    chk("r30_pc_zero_src", pc, 32'h0);
    rd_cnt = 0; done_cnt = 0;
    fetch_pulse();
    cycle();
    ins_load = 1;
    cycle();
    ins_load = 0;
    run(5);
    chk("r30_single_done", done_cnt, 1);

    // Reset in WAIT aborts the fetch
    load_pc(2'd0, 32'h0000_0100);
    fetch_pulse();
    cycle();
    rst = 1'b1;
    #1;
    chk("r31_busy", {31'b0, busy}, 0);
    chk("r31_mem_rd", {31'b0, mem_rd}, 0);
    chk("r31_mem_addr", mem_addr, 0);
    chk("r31_fetch_done", {31'b0, fetch_done}, 0);
    chk("r31_pc", pc, 0);
    chk("r31_ir", ir, 0);
    model_reset();
    cycle();
    rst = 1'b0;
    rd_cnt = 0; done_cnt = 0;
    run(5);
    chk("r31_no_done", done_cnt, 0);
    chk("r31_ir_after", ir, 0);

    // Misaligned pc
    load_pc(2'd0, 32'h0000_0002);
    rd_cnt = 0; done_cnt = 0;
    fetch_pulse();
`ifdef FETCH_MISALIGN_EN
    chk("r32_misalign", {31'b0, misalign}, 1);
    chk("r32_busy", {31'b0, busy}, 1);
    run(5);
    load_pc(2'd0, 32'h0000_0040);
    chk("r32_pc_in_fault", pc, 32'h40);
    chk("r32_no_rd", rd_cnt, 0);
    chk("r32_no_done", done_cnt, 0);
    do_reset();
    chk("r32_cleared", {31'b0, misalign}, 0);
`else
    chk("r32_mem_addr", mem_addr, 0);
    chk("r32_misalign", {31'b0, misalign}, 0);
    run(4);
    chk("r32_rd_cycles", rd_cnt, 2);
    chk("r32_done", done_cnt, 1);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ins_load   = ($urandom % 3) == 0;
      pc_load    = ($urandom % 4) == 0;
      mux_pcin   = 2'($urandom);
      alu_result = $urandom;
      aluout     = $urandom;
`ifdef FETCH_MISALIGN_EN
      alu_result[1:0] = 2'b00;
      aluout[1:0]     = 2'b00;
`endif
      if ((i % 150) == 149) do_reset();
      else cycle();
    end
    ins_load = 0; pc_load = 0;
    run(5);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk  input  1  system clock, all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have port pc_load  input  1  update PC this cycle from the mux_pcin-selected source.
REQ-004 SHALL have port ins_load  input  1  request an instruction fetch; sampled in IDLE only.
REQ-005 SHALL have port mux_pcin  input  2  PC source: 0 alu_result, 1 aluout, 2 jump target {pc_fetch[31:28],ir[25:0],2'b00}, 3 32'h0.
REQ-006 SHALL have ports alu_result, aluout  input  32 each  ALU combinational result / ALUOut register.
REQ-007 SHALL have ports mem_rdata  input  32  memory read data; mem_addr  output  32  read address; mem_rd  output  1  read strobe.
REQ-008 SHALL have port pc  output  32  current PC register.
REQ-009 SHALL have port ir  output  32  instruction register, plus field outputs opcode[5:0]=ir[31:26], rs[4:0]=ir[25:21], rt[4:0]=ir[20:16], rd[4:0]=ir[15:11], shamt[4:0]=ir[10:6], funct[5:0]=ir[5:0], imm16[15:0]=ir[15:0], all combinational from ir.
REQ-010 SHALL have ports fetch_done  output  1  one-cycle pulse when ir is updated; busy  output  1  high in any state except IDLE; misalign  output  1  sticky misaligned-fetch flag.

Function
REQ-011 SHALL implement FSM IDLE -> ADDR -> WAIT -> LATCH -> IDLE, one state per cycle.
REQ-012 In IDLE with ins_load=1, SHALL capture pc into pc_fetch and go to ADDR; ins_load=0 stays IDLE.
REQ-013 In ADDR and WAIT, SHALL drive mem_rd=1 and mem_addr=pc_fetch; other states mem_rd=0, mem_addr holds pc_fetch.
REQ-014 Memory latency is fixed at 2 cycles: mem_rdata valid in LATCH; in LATCH ir <= mem_rdata and fetch_done=1 for that cycle (registered ir visible the following cycle, total ins_load->ir latency 4 cycles).
REQ-015 ins_load asserted outside IDLE SHALL be ignored; no queued request.
REQ-016 pc_load SHALL be honoured in every state, independent of the FSM; pc <= selected source on that edge.
REQ-017 Simultaneous ins_load and pc_load in IDLE: pc_fetch SHALL capture the old pc; pc takes the new value.
REQ-018 PC arithmetic is 32-bit unsigned, wrap-around at 32'hFFFF_FFFF with no flag.
REQ-019 Jump target (mux_pcin=2) SHALL use pc_fetch[31:28] and the current ir, not mem_rdata.
REQ-020 ir SHALL hold its value except in LATCH.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, pc=0, pc_fetch=0, ir=0, mem_rd=0, mem_addr=0, fetch_done=0, busy=0, misalign=0.
REQ-022 Reset mid-fetch SHALL abort; no ir update or fetch_done for the aborted fetch after release.
REQ-023 First cycle after rst deasserts SHALL be IDLE, accepting ins_load.

Configuration
REQ-024 Macro FETCH_MISALIGN_EN.
REQ-025 Defined: in IDLE with ins_load=1 and pc[1:0]!=0, SHALL set misalign=1, enter FAULT state, never assert mem_rd or fetch_done; FAULT holds until rst; busy=1 in FAULT; pc_load still honoured.
REQ-026 Not defined: mem_addr SHALL be {pc_fetch[31:2],2'b00}, misalign tied 0, no FAULT state.

Verification
REQ-027 Reset then ins_load=1 one cycle, mem_rdata=32'h2008_0005 in LATCH -> mem_rd high 2 cycles at addr 0, fetch_done one pulse, opcode=6'h08, rt=8, imm16=16'h0005.
REQ-028 pc=32'h0000_0004, ins_load=1 and pc_load=1 with mux_pcin=0, alu_result=32'h0000_0008 same cycle -> mem_addr=4, pc=8.
REQ-029 ir=32'h0800_0010, pc_fetch=32'h4000_0000, pc_load with mux_pcin=2 -> pc=32'h4000_0040.
REQ-030 pc=32'hFFFF_FFFC, pc_load mux_pcin=0 alu_result=32'h0 -> pc=0; ins_load during WAIT ignored, exactly one fetch_done.
REQ-031 Assert rst in WAIT -> all outputs zero immediately, no fetch_done after release, ir=0.
REQ-032 pc=32'h0000_0002, ins_load: with FETCH_MISALIGN_EN misalign=1, mem_rd stays 0; without it mem_addr=0 and fetch completes normally.
